axi_vfifo_reader: RTL and testbench

Read side of the AXI4-backed virtual FIFO, successor to the single-burst reader. Converts the wr_ptr/rd_ptr occupancy of a ring buffer in AXI memory into AXI4 INCR read bursts and streams the returned beats to an AXI4-Stream initiator. Adds multiple outstanding bursts, 4 KB / buffer-wrap burst splitting, an enable/drain mode, RRESP error capture and busy status.

---
 rtl/axi_vfifo_reader.sv | 147 ++++++++++++++
 tb/tb_axi_vfifo_reader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_vfifo_reader.sv
// Purpose: converts ring-buffer occupancy (wr_ptr vs. issued pointer) into AXI4 INCR read bursts and streams returned beats out.
// Latency: AR is presented one cycle after data becomes available; the R -> stream path is combinational (zero cycles).
// Backpressure: initiator_tready drives mem_rready directly; AR issue is throttled by MAX_OUTSTANDING and enable.
module axi_vfifo_reader #(
  parameter int unsigned TDATA_BYTES     = 8,
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter int unsigned MAX_BURST_LEN   = 256,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter logic [3:0]  AXI_ID          = 4'd0,
  localparam int unsigned LOG_B          = $clog2(TDATA_BYTES),
  localparam int unsigned P              = ADDR_WIDTH - LOG_B + 1
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       enable,
  output logic                       mem_arvalid,
  input  logic                       mem_arready,
  output logic [ADDR_WIDTH-1:0]      mem_araddr,
  output logic [7:0]                 mem_arlen,
  output logic [2:0]                 mem_arsize,
  output logic [1:0]                 mem_arburst,
  output logic [3:0]                 mem_arid,
  input  logic                       mem_rvalid,
  output logic                       mem_rready,
  input  logic [8*TDATA_BYTES-1:0]   mem_rdata,
  input  logic [3:0]                 mem_rid,
  input  logic [1:0]                 mem_rresp,
  input  logic                       mem_rlast,
  output logic                       initiator_tvalid,
  input  logic                       initiator_tready,
  output logic [8*TDATA_BYTES-1:0]   initiator_tdata,
  input  logic [P-1:0]               wr_ptr,
  output logic [P-1:0]               rd_ptr,
  output logic                       busy,
  output logic                       err,
  input  logic                       err_clear
);

  // Bursts may cross neither a 4 KB page nor the end of the ring buffer.
  localparam int unsigned BND_BYTES = (ADDR_WIDTH >= 12) ? 4096 : (1 << ADDR_WIDTH);
  localparam int unsigned BND_BEATS = BND_BYTES / TDATA_BYTES;
  localparam int unsigned OCW       = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
  } ar_req_t;

  logic            ar_vld_q, ar_vld_d;
  ar_req_t         ar_q, ar_d;
  logic [P-1:0]    ar_ptr_q, ar_ptr_d;
  logic [P-1:0]    beat_cnt_q, beat_cnt_d;
  logic [P-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OCW-1:0]  outst_q, outst_d;
  logic            err_q, err_d;

  logic            ar_hs, r_hs, rlast_hs, can_issue;
  logic [P-1:0]    avail;
  logic [31:0]     to_bnd, burst_len;
  logic            unused_rid;

  assign ar_hs      = ar_vld_q & mem_arready;
  assign r_hs       = mem_rvalid & initiator_tready;
  assign rlast_hs   = r_hs & mem_rlast;
  assign avail      = wr_ptr - ar_ptr_q;
  assign unused_rid = ^mem_rid;

  // Pure pass-through data path; the memory sees the stream's ready directly.
  assign initiator_tvalid = mem_rvalid;
  assign initiator_tdata  = mem_rdata;
  assign mem_rready       = initiator_tready;

  assign mem_arvalid = ar_vld_q;
  assign mem_araddr  = ar_q.addr;
  assign mem_arlen   = ar_q.len;
  assign mem_arsize  = 3'(LOG_B);
  assign mem_arburst = 2'b01;
  assign mem_arid    = AXI_ID;
  assign rd_ptr      = rd_ptr_q;
  assign err         = err_q;
  assign busy        = ar_vld_q | (outst_q != '0);

  // Burst length: smallest of available beats, max burst and beats left before the boundary.
  always_comb begin
    to_bnd    = BND_BEATS - (32'(ar_ptr_q) & (BND_BEATS - 1));
    burst_len = 32'(avail);
    if (burst_len > MAX_BURST_LEN) burst_len = MAX_BURST_LEN;
    if (burst_len > to_bnd)        burst_len = to_bnd;
  end

  // Next-state: outstanding count, AR issue/reload, read pointer commit and error flag.
  always_comb begin
    outst_d    = outst_q;
    ar_vld_d   = ar_vld_q;
    ar_d       = ar_q;
    ar_ptr_d   = ar_ptr_q;
    beat_cnt_d = beat_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    err_d      = err_q;

    if (ar_hs && !rlast_hs)      outst_d = outst_q + 1'b1;
    else if (!ar_hs && rlast_hs) outst_d = outst_q - 1'b1;

    // A new request may replace one being accepted this cycle; the limit uses the post-cycle count.
    can_issue = (!ar_vld_q || ar_hs) && enable && (avail != '0) &&
                (32'(outst_d) < MAX_OUTSTANDING);

    if (can_issue) begin
      ar_vld_d   = 1'b1;
      ar_d.addr  = ADDR_WIDTH'(ar_ptr_q[P-2:0]) << LOG_B;
      ar_d.len   = 8'(burst_len - 1);
      ar_ptr_d   = ar_ptr_q + P'(burst_len);
    end else if (ar_hs) begin
      ar_vld_d   = 1'b0;
    end

    // rd_ptr only advances once a whole burst has been handed downstream.
    if (r_hs)     beat_cnt_d = beat_cnt_q + 1'b1;
    if (rlast_hs) rd_ptr_d   = beat_cnt_q + 1'b1;

    // A new error beat wins over a simultaneous clear.
    if (r_hs && (mem_rresp != 2'b00)) err_d = 1'b1;
    else if (err_clear)               err_d = 1'b0;
  end

  // State registers with asynchronous reset; in-flight bursts are simply abandoned.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ar_vld_q   <= 1'b0;
      ar_q       <= '0;
      ar_ptr_q   <= '0;
      beat_cnt_q <= '0;
      rd_ptr_q   <= '0;
      outst_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      ar_vld_q   <= ar_vld_d;
      ar_q       <= ar_d;
      ar_ptr_q   <= ar_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      outst_q    <= outst_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_vfifo_reader.sv
// Purpose: self-checking bench for axi_vfifo_reader with a memory-side responder and AR/R scoreboards.
// Latency: responder answers an accepted AR from the next cycle on, or when released by the test.
// Backpressure: arready/tready/rvalid are randomised in bulk phases and held high in exact phases.
module tb_axi_vfifo_reader;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        enable;
  logic        mem_arvalid, mem_arready;
  logic [15:0] mem_araddr;
  logic [7:0]  mem_arlen;
  logic [2:0]  mem_arsize;
  logic [1:0]  mem_arburst;
  logic [3:0]  mem_arid, mem_rid;
  logic        mem_rvalid, mem_rready, mem_rlast;
  logic [63:0] mem_rdata, initiator_tdata;
  logic [1:0]  mem_rresp;
  logic        initiator_tvalid, initiator_tready;
  logic [13:0] wr_ptr, rd_ptr;
  logic        busy, err, err_clear;

  axi_vfifo_reader dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable),
    .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
    .mem_arlen(mem_arlen), .mem_arsize(mem_arsize), .mem_arburst(mem_arburst), .mem_arid(mem_arid),
    .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata), .mem_rid(mem_rid),
    .mem_rresp(mem_rresp), .mem_rlast(mem_rlast),
    .initiator_tvalid(initiator_tvalid), .initiator_tready(initiator_tready),
    .initiator_tdata(initiator_tdata),
    .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .busy(busy), .err(err), .err_clear(err_clear)
  );

  initial forever #5 aclk = ~aclk;

  typedef struct packed { logic [15:0] addr; logic [7:0] len; logic [13:0] rd; } arexp_t;
  typedef struct packed { logic rst; logic chk; logic rnd; logic [13:0] wr; logic [3:0] n_ar; logic [13:0] rd_end; } vec_t;
  typedef struct packed { logic [15:0] addr; logic [7:0] len; } ar_t;

  int checks = 0;
  int errors = 0;

  // test controls (written by the main sequence only)
  bit r_hold;
  bit rnd_mode;
  bit ar_chk;
  int err_beat;

  // scoreboards
  arexp_t      ar_exp[$];
  logic [13:0] rd_exp[$];
  ar_t         resp_q[$];
  logic [63:0] data_q[$];

  // responder/monitor state
  int          ar_seen;
  int          beat_total;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pat(input logic [15:0] a);
    return {16'hA5C3, a, ~a, a ^ 16'h5A5A};
  endfunction

  // Memory model + monitor: drives R at the falling edge, records handshakes 1 time unit later.
  initial begin : responder
    int  beat;
    bit  r_acc;
    bit  rl_prev;
    bit  stall_prev;
    ar_t stall_ar;
    logic [13:0] last_rd;
    arexp_t e;
    beat = 0; r_acc = 0; rl_prev = 0; stall_prev = 0; stall_ar = '0; last_rd = '0;
    ar_seen = 0; beat_total = 0;
    mem_arready = 1'b1; initiator_tready = 1'b1; mem_rvalid = 1'b0; mem_rlast = 1'b0;
    mem_rresp = 2'b00; mem_rdata = '0; mem_rid = 4'd0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        resp_q.delete(); data_q.delete(); rd_exp.delete();
        beat = 0; r_acc = 0; rl_prev = 0; stall_prev = 0; last_rd = '0; beat_total = 0;
        mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_rresp = 2'b00;
        continue;
      end
      mem_arready      = rnd_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
      initiator_tready = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (!mem_rvalid || r_acc) begin
        if (!r_hold && resp_q.size() != 0 && (!rnd_mode || $urandom_range(0, 3) != 0)) begin
          mem_rvalid = 1'b1;
          mem_rdata  = pat(resp_q[0].addr + 16'(beat * 8));
          mem_rlast  = (beat == int'(resp_q[0].len));
          mem_rresp  = (beat_total == err_beat) ? 2'b10 : 2'b00;
        end else begin
          mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_rresp = 2'b00;
        end
      end
      #1;
      if (!aresetn) continue;
      // rd_ptr moves exactly after an RLAST handshake and nowhere else
      if (rl_prev) begin
        if (ar_chk && rd_exp.size() != 0) check("rd_ptr_step", rd_ptr, rd_exp.pop_front());
      end else begin
        check("rd_ptr_hold", rd_ptr, last_rd);
      end
      last_rd = rd_ptr;
      rl_prev = 0;
      check("tvalid_pass", initiator_tvalid, mem_rvalid);
      check("rready_pass", mem_rready, initiator_tready);
      if (stall_prev) begin
        check("ar_hold_vld", mem_arvalid, 1'b1);
        check("ar_hold_addr", mem_araddr, stall_ar.addr);
        check("ar_hold_len", mem_arlen, stall_ar.len);
      end
      r_acc = mem_rvalid && mem_rready;
      if (r_acc) begin
        if (data_q.size() == 0) check("r_extra", mem_rvalid, 1'b0);
        else check("tdata", initiator_tdata, data_q.pop_front());
        beat_total++;
        if (mem_rlast) begin
          void'(resp_q.pop_front());
          beat = 0;
          rl_prev = 1;
        end else begin
          beat++;
        end
      end
      if (mem_arvalid && mem_arready) begin
        ar_seen++;
        check("arsize", mem_arsize, 3'd3);
        check("arburst", mem_arburst, 2'b01);
        check("arid", mem_arid, 4'd0);
        if (ar_chk) begin
          if (ar_exp.size() == 0) begin
            check("ar_extra", mem_arvalid, 1'b0);
          end else begin
            e = ar_exp.pop_front();
            check("araddr", mem_araddr, e.addr);
            check("arlen", mem_arlen, e.len);
            rd_exp.push_back(e.rd);
          end
        end
        resp_q.push_back('{mem_araddr, mem_arlen});
        for (int i = 0; i <= int'(mem_arlen); i++) data_q.push_back(pat(mem_araddr + 16'(i * 8)));
      end
      stall_prev = mem_arvalid && !mem_arready;
      stall_ar   = '{mem_araddr, mem_arlen};
    end
  end

  task automatic do_reset();
    @(posedge aclk);
    #3;
    aresetn = 1'b0;
    wr_ptr = '0; enable = 1'b1; r_hold = 0; rnd_mode = 0; ar_chk = 0;
    ar_exp.delete();
    #1;
    check("rst_arvalid", mem_arvalid, 1'b0);
    check("rst_araddr", mem_araddr, 16'h0);
    check("rst_arlen", mem_arlen, 8'h0);
    check("rst_rd_ptr", rd_ptr, 14'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    repeat (3) @(posedge aclk);
    #3;
    aresetn = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    repeat (3) @(negedge aclk);
    for (int t = 0; t < 30000 && busy; t++) @(negedge aclk);
    check(name, busy, 1'b0);
  endtask

  vec_t   vecs[7];
  arexp_t ars[10];

  initial begin : main
    int ai;
    int base;
    aresetn = 1'b1; enable = 1'b1; wr_ptr = '0; err_clear = 1'b0;
    r_hold = 0; rnd_mode = 0; ar_chk = 0; err_beat = -1;

    //          rst   chk   rnd   wr        n_ar  rd_end
    vecs[0] = '{1'b1, 1'b1, 1'b0, 14'd10,   4'd1, 14'd10};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 14'd600,  4'd3, 14'd600};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 14'd500,  4'd2, 14'd500};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 14'd530,  4'd2, 14'd530};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 14'd4096, 4'd0, 14'd4096};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 14'd8184, 4'd0, 14'd8184};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 14'd8204, 4'd2, 14'd8204};
    //         araddr     arlen    rd_ptr after RLAST
    ars[0] = '{16'h0000, 8'd9,   14'd10};
    ars[1] = '{16'h0000, 8'd255, 14'd256};
    ars[2] = '{16'h0800, 8'd255, 14'd512};
    ars[3] = '{16'h1000, 8'd87,  14'd600};
    ars[4] = '{16'h0000, 8'd255, 14'd256};
    ars[5] = '{16'h0800, 8'd243, 14'd500};
    ars[6] = '{16'h0FA0, 8'd11,  14'd512};
    ars[7] = '{16'h1000, 8'd17,  14'd530};
    ars[8] = '{16'hFFC0, 8'd7,   14'd8192};
    ars[9] = '{16'h0000, 8'd11,  14'd8204};

    ai = 0;
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].rst) do_reset();
      r_hold = vecs[v].chk; rnd_mode = vecs[v].rnd; ar_chk = vecs[v].chk;
      base = ar_seen;
      for (int k = 0; k < int'(vecs[v].n_ar); k++) ar_exp.push_back(ars[ai++]);
      @(negedge aclk);
      wr_ptr = vecs[v].wr;
      if (vecs[v].chk) begin
        for (int t = 0; t < 200 && (ar_seen - base) < int'(vecs[v].n_ar); t++) @(negedge aclk);
        repeat (10) @(negedge aclk);
        check("ar_count", 64'(ar_seen - base), 64'(vecs[v].n_ar));
        r_hold = 0;
      end
      wait_idle("vec_idle");
      check("vec_rd_ptr", rd_ptr, vecs[v].rd_end);
      check("vec_err", err, 1'b0);
      check("vec_ar_left", 64'(ar_exp.size()), 64'd0);
    end

    // Outstanding limit, then drain with enable low.
    do_reset();
    r_hold = 1; ar_chk = 1;
    base = ar_seen;
    ar_exp.push_back('{16'h0000, 8'd255, 14'd256});
    ar_exp.push_back('{16'h0800, 8'd255, 14'd512});
    ar_exp.push_back('{16'h1000, 8'd255, 14'd768});
    ar_exp.push_back('{16'h1800, 8'd255, 14'd1024});
    @(negedge aclk);
    wr_ptr = 14'd2048;
    for (int t = 0; t < 200 && (ar_seen - base) < 4; t++) @(negedge aclk);
    for (int t = 0; t < 30; t++) begin
      @(negedge aclk);
      #2;
      check("limit_arvalid", mem_arvalid, 1'b0);
    end
    check("limit_busy", busy, 1'b1);
    enable = 1'b0;
    r_hold = 0;
    wait_idle("drain_idle");
    check("drain_rd_ptr", rd_ptr, 14'd1024);
    check("drain_ar_count", 64'(ar_seen - base), 64'd4);

    // RRESP error on beat 3: sticky until cleared, data still forwarded.
    do_reset();
    ar_chk = 1;
    ar_exp.push_back('{16'h0000, 8'd9, 14'd10});
    err_beat = 3;
    @(negedge aclk);
    wr_ptr = 14'd10;
    wait_idle("err_idle");
    check("err_set", err, 1'b1);
    check("err_rd_ptr", rd_ptr, 14'd10);
    repeat (5) @(negedge aclk);
    check("err_sticky", err, 1'b1);
    err_clear = 1'b1;
    @(negedge aclk);
    err_clear = 1'b0;
    check("err_cleared", err, 1'b0);
    err_beat = -1;

    // Asynchronous reset in the middle of a burst (error flag set beforehand).
    do_reset();
    err_beat = 5;
    @(negedge aclk);
    wr_ptr = 14'd300;
    for (int t = 0; t < 400 && beat_total < 20; t++) @(negedge aclk);
    check("mid_busy", busy, 1'b1);
    check("mid_err", err, 1'b1);
    do_reset();
    err_beat = -1;
    repeat (3) @(negedge aclk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
